// File: rtl/maxpool_l0_l1.sv
// 2x2 max-pool: reads a 64x64 layer-0 map, writes the 32x32 map of window maxima to layer 1.
// Ports: clk, reset (async high), start -> busy/done; crd/caddr_rd/cdata_rd read port;
// cwr/caddr_wr/cdata_wr write port; csel selects layer 0 (001), layer 1 (011) or idle (000).
module maxpool_l0_l1 #(
    parameter int DW = 20,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_WR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [9:0]    o_q, o_d;
    logic [DW-1:0] max_q, max_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] bigger;
    logic [11:0]   rd_addr;

    // Window base {oy,0,ox,0} plus offset {0,1,64,65}[k] folds into
    // the two spare bits of the base address.
    assign rd_addr = {o_q[9:5], k_q[1], o_q[4:0], k_q[0]};
    assign bigger  = (cdata_rd > max_q) ? cdata_rd : max_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            o_q     <= '0;
            max_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            o_q     <= o_d;
            max_q   <= max_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        o_d     = o_q;
        max_d   = max_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD;
                    k_d     = '0;
                    o_d     = '0;
                end
            end
            S_RD: begin
                k_d = k_q + 2'd1;
                // Data lags the address by one cycle: k=1 sees sample 0.
                if (k_q == 2'd1) begin
                    max_d = cdata_rd;
                end else if (k_q[1]) begin
                    max_d = bigger;
                end
                if (k_q == 2'd3) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                // Write registers are loaded here so they are stable in WR.
                max_d   = bigger;
                wa_d    = AW'(o_q);
                wd_d    = bigger;
                state_d = S_WR;
            end
            S_WR: begin
                if (o_q == 10'd1023) begin
                    state_d = S_DONE;
                end else begin
                    o_d     = o_q + 10'd1;
                    k_d     = '0;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        crd      = (state_q == S_RD);
        cwr      = (state_q == S_WR);
        done     = (state_q == S_DONE);
        busy     = (state_q == S_RD) || (state_q == S_CMP) || (state_q == S_WR);
        caddr_rd = crd ? AW'(rd_addr) : '0;
        caddr_wr = wa_q;
        cdata_wr = wd_q;
        csel     = 3'b000;
        if ((state_q == S_RD) || (state_q == S_CMP)) begin
            csel = 3'b001;
        end else if (state_q == S_WR) begin
            csel = 3'b011;
        end
    end

endmodule

// File: tb/tb_maxpool_l0_l1.sv
// Randomized self-checking bench for maxpool_l0_l1.
// Per-cycle outputs are checked against a timing/arithmetic model of the frame.
module tb_maxpool_l0_l1;
    localparam int DW = 20;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, crd, cwr;
    logic [AW-1:0] caddr_rd, caddr_wr;
    logic [DW-1:0] cdata_rd = '0;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    logic [DW-1:0] mem [4096];
    logic [DW-1:0] l1 [1024];
    int nwr = 0;
    int vectors = 0;
    int miscompares = 0;

    bit m_act = 1'b0;
    int rel = 0;

    maxpool_l0_l1 #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency and a write log.
    always @(posedge clk) begin
        if (crd) cdata_rd <= mem[caddr_rd];
        if (cwr) begin
            l1[caddr_wr[9:0]] <= cdata_wr;
            nwr <= nwr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_max(input int p);
        int oy, ox, b;
        logic [DW-1:0] m;
        int offs [4];
        offs = '{0, 1, 64, 65};
        oy = p / 32;
        ox = p % 32;
        b = (2 * oy) * 64 + 2 * ox;
        m = 0;
        for (int j = 0; j < 4; j++)
            if (mem[b + offs[j]] > m) m = mem[b + offs[j]];
        return m;
    endfunction

    // Model: cycle index since the accepting edge; 6144 is the done cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act <= 1'b0;
            rel <= 0;
        end else if (m_act) begin
            if (rel == 6144) m_act <= 1'b0;
            else rel <= rel + 1;
        end else if (start) begin
            m_act <= 1'b1;
            rel <= 0;
        end
    end

    always @(negedge clk) begin : cmp
        int p, ph, a;
        if (!reset && m_act && rel < 6144) begin
            p = rel / 6;
            ph = rel % 6;
            chk("busy", busy, 1);
            chk("done", done, 0);
            chk("crd", crd, (ph < 4) ? 1 : 0);
            chk("cwr", cwr, (ph == 5) ? 1 : 0);
            chk("csel", csel, (ph == 5) ? 3 : 1);
            if (ph < 4) begin
                a = (2 * (p / 32) + ph / 2) * 64 + 2 * (p % 32) + ph % 2;
                chk("caddr_rd", caddr_rd, a);
            end
            if (ph == 5) begin
                chk("caddr_wr", caddr_wr, p);
                chk("cdata_wr", cdata_wr, exp_max(p));
            end
        end else if (!reset && m_act) begin
            chk("done_pulse", done, 1);
            chk("busy_done", busy, 0);
            chk("strobes_done", {crd, cwr, csel}, 0);
        end else begin
            chk("idle_busy_done", {busy, done}, 0);
            chk("idle_strobes", {crd, cwr, csel}, 0);
        end
    end

    task automatic run_frame(input bit pulse, output int lat);
        @(negedge clk) start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 7000; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            start = (pulse && i == 100) ? 1'b1 : 1'b0;
        end
        start = pulse;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    endtask

    int lat, n0;
    bit found;

    initial begin
        rand_mem();
        #2 reset = 1'b1;
        #1;
        chk("rst_strobes", {crd, cwr, busy, done, csel}, 0);
        chk("rst_caddr_rd", caddr_rd, 0);
        chk("rst_caddr_wr", caddr_wr, 0);
        chk("rst_cdata_wr", cdata_wr, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        mem[0] = 5; mem[1] = 9; mem[64] = 3; mem[65] = 7;
        for (int p = 1; p <= 4; p++) begin
            mem[2*p] = 0; mem[2*p+1] = 0; mem[2*p+64] = 0; mem[2*p+65] = 0;
        end
        mem[2] = 20'hFFFFF;
        mem[5] = 20'hFFFFF;
        mem[70] = 20'hFFFFF;
        mem[73] = 20'hFFFFF;
        mem[10] = 20'h80000; mem[11] = 20'h7FFFF; mem[74] = 20'h7FFFF; mem[75] = 20'h7FFFF;
        mem[12] = 20'h7FFFF; mem[13] = 20'h00001; mem[76] = 20'h00000; mem[77] = 20'h80000;
        chk("model_w0", exp_max(0), 9);
        chk("model_w6", exp_max(6), 20'h80000);

        n0 = nwr;
        run_frame(1'b0, lat);
        chk("latency1", lat, 6145);
        chk("nwrites1", nwr - n0, 1024);
        chk("w0", l1[0], 9);
        for (int p = 1; p <= 4; p++) chk("wmax_pos", l1[p], 20'hFFFFF);
        chk("w5_unsigned", l1[5], 20'h80000);
        chk("w6_unsigned", l1[6], 20'h80000);

        rand_mem();
        n0 = nwr;
        run_frame(1'b1, lat);
        chk("latency2", lat, 6145);
        chk("nwrites2", nwr - n0, 1024);
        chk("last_window", l1[1023], exp_max(1023));

        rand_mem();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (cwr && caddr_wr == 300) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_wr300", found, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_strobes", {crd, cwr, busy, done, csel}, 0);
        chk("midrst_caddr_wr", caddr_wr, 0);
        chk("midrst_cdata_wr", cdata_wr, 0);
        n0 = nwr;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_writes_after_rst", nwr - n0, 0);

        rand_mem();
        n0 = nwr;
        run_frame(1'b0, lat);
        chk("latency3", lat, 6145);
        chk("nwrites3", nwr - n0, 1024);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/maxpool_l0_l1.md
# maxpool_l0_l1

Downstream 2x2 max-pool stage of the convolution datapath. After the conv/ReLU stage has filled layer-0 memory with a 64x64 map of 20-bit results, this block reads that memory, takes the maximum of each non-overlapping 2x2 window, and writes the resulting 32x32 map to layer-1 memory. It uses the shared `crd`/`cwr`/`csel` memory port protocol, so the top level can mux it onto the same memory as the conv stage.

## Interface
- `DW`, default 20: data word width.
- `AW`, default 12: memory address width (64x64 = 4096 words).
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle request to pool the full frame; sampled only in IDLE.
- `busy`  output  1  high from the cycle after `start` is accepted until the cycle `done` is asserted; reset 0.
- `done`  output  1  one-cycle pulse after the last layer-1 write; reset 0.
- `crd`  output  1  memory read strobe; reset 0.
- `caddr_rd`  output  AW  layer-0 read address; reset 0.
- `cdata_rd`  input  DW  read data, valid the cycle after the `crd`/`caddr_rd` cycle.
- `cwr`  output  1  memory write strobe; reset 0.
- `caddr_wr`  output  AW  layer-1 write address, range 0..1023; reset 0.
- `cdata_wr`  output  DW  write data; reset 0.
- `csel`  output  3  memory select: 3'b001 = layer 0 (read), 3'b011 = layer 1 (write), 3'b000 = idle; reset 3'b000.

## Operation
- **States:** IDLE, RD, CMP, WR, DONE.
- **IDLE:** if `start`=1, go to RD with `k`=0 and output index `o`=0. Otherwise stay.
- **Output index:** `o` = {oy[4:0], ox[4:0]}. The window base address is `base` = {oy, 1'b0, ox, 1'b0}, which equals (2·oy)·64 + 2·ox.
- **RD (4 cycles, k=0..3):**
  - Drive `crd`=1, `csel`=001, `caddr_rd` = `base` + {0, 1, 64, 65}[k].
  - For k=3, go to CMP.
- **Data capture:**
  - In RD with k=1, load `max` = `cdata_rd` unconditionally. This is the first sample.
  - In RD with k=2..3, and in CMP, set `max` = (`cdata_rd` > `max`) ? `cdata_rd` : `max`.
  - The comparison is unsigned, DW bits. Ties keep the earlier value; the result is identical either way.
- **CMP (1 cycle):** `crd`=1 is not required. Drive `crd`=0, `csel`=001. Capture the 4th sample, then go to WR.
- **WR (1 cycle):**
  - Drive `cwr`=1, `csel`=011, `caddr_wr`=`o`, `cdata_wr`=`max`.
  - If `o`=1023, go to DONE.
  - Otherwise set `o`=`o`+1 and go to RD with k=0. `ox` wraps from 31 to 0 and increments `oy`.
- **DONE (1 cycle):** `done`=1, `busy`=0, then go to IDLE.
- **Strobe rules:**
  - `crd` and `cwr` are never high in the same cycle.
  - `csel` is 000 in IDLE and DONE.
  - `caddr_wr` and `cdata_wr` hold their last values outside WR. They are don't-care when `cwr`=0, but must be stable (registered).
- **Ignored start:** `start` while not in IDLE is ignored. It is not queued.
- **Reset mid-operation:** go to IDLE immediately and clear all outputs and counters. No partial write completes. The next `start` begins again at `o`=0.
- **Output timing:** all outputs are functions of registered state and counters only. There is no combinational path from `start` or `cdata_rd` to any output.

## Timing
- **Per output pixel:** 6 cycles (RD×4, CMP, WR).
- **Start to done:**
  - `start` is sampled high at edge T0; first RD cycle is T0..T1.
  - The first write occurs in cycle 5 after acceptance.
  - The 1024th write is in cycle 6143 (0-based from the first RD).
  - `done` is high in cycle 6144.
- **Total latency:** `start` edge to `done` high is 6145 cycles.
- **Busy window:** `busy` is high in every RD/CMP/WR cycle, i.e. 6144 cycles.
- **Read data alignment:** `cdata_rd` for the read issued in cycle n is sampled at the end of cycle n+1. The block relies on exactly this 1-cycle memory read latency.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → all outputs 0 and `csel`=000 immediately. After release the block stays IDLE with no strobes.
- **Window 0:** layer0[0]=5, [1]=9, [64]=3, [65]=7 → reads at addresses 0, 1, 64, 65 in 4 consecutive cycles, then a write with `caddr_wr`=0 and `cdata_wr`=9 two cycles after the last read.
- **Max position and extremes:** for each window in turn, place the max at each of the 4 positions, including 20'hFFFFF against 0 → the written value always equals the max. This confirms unsigned compare and that the first sample is loaded without comparison.
- **Full frame:** random 64x64 frame → 1024 writes, addresses 0..1023 in order. The last read addresses are 4030, 4031, 4094, 4095. Every value matches the reference model. `done` is a 1-cycle pulse exactly 6145 cycles after `start`.
- **Start while busy:** pulse `start` while busy → ignored, with no restart and unchanged timing. A second `start` after `done` → full rerun from `o`=0.
- **Reset mid-frame:** assert `reset` during WR of `o`=300 → no further strobes. A new `start` then produces a write sequence beginning at `caddr_wr`=0.
